// File: rtl/pov_pkg.sv
// Shared types and constants for the POV fan frame scheduler.
// Contents:
//   pov_state_t  - scheduler state encoding (IDLE=0, PLAY=1, PAUSE=2)
//   DEG_MAX_DEF  - default number of angle steps per revolution
//   DEG_W        - width of the angle counter / deg output
package pov_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2
  } pov_state_t;

  localparam int DEG_MAX_DEF = 360;
  localparam int DEG_W       = 9;

endpackage

// File: rtl/fan_tick_detect.sv
// Rising-edge detector for the fan angle sensor.
// fanclk is already synchronous to clk, so a single history register is
// enough. A level held high for any number of cycles yields one tick.
// Ports:
//   clk    in  system clock
//   rst    in  synchronous, active-high reset
//   fanclk in  angle pulse level from the fan sensor
//   tick   out one-cycle pulse on each fanclk rising edge (combinational)
module fan_tick_detect
  import pov_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic fanclk,
  output logic tick
);

  logic fanclk_q;

  always_ff @(posedge clk) begin
    if (rst) fanclk_q <= 1'b0;
    else     fanclk_q <= fanclk;
  end

  assign tick = fanclk & ~fanclk_q;

endmodule

// File: rtl/pov_frame_scheduler.sv
// Frame sequencer for the POV LED fan.
// Turns fanclk into a down-counting angle (DEG_MAX..1) and changes the
// displayed frame only at revolution boundaries so the image never tears.
// Optional build macro:
//   PINGPONG_EN - frames run 0..N-1..0 back and forth instead of wrapping.
// Ports:
//   clk       in  system clock
//   rst       in  synchronous, active-high reset
//   fanclk    in  fan angle pulse level (clk-synchronous)
//   en        in  0 forces IDLE and clears the schedule
//   run       in  1 = PLAY, 0 = PAUSE (while en=1)
//   step      in  one-cycle request for a single frame advance in PAUSE
//   hold_revs in  revolutions per frame in PLAY (0 behaves as 1)
//   deg       out current angle, DEG_MAX..1
//   frame_idx out current frame
//   rev_done  out one-cycle pulse when deg reloads to DEG_MAX
//   frame_adv out one-cycle pulse when frame_idx changes
//   state     out scheduler state
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | disabled; angle and frame held at reset values, ticks ignored
// PLAY  | angle counts; frame advances every max(hold_revs,1) revs
// PAUSE | angle counts; rev_cnt frozen; a pending step advances at wrap
module pov_frame_scheduler
  import pov_pkg::*;
#(
  parameter int DEG_MAX    = DEG_MAX_DEF,
  parameter int NUM_FRAMES = 6,
  parameter int FW         = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             fanclk,
  input  logic             en,
  input  logic             run,
  input  logic             step,
  input  logic [7:0]       hold_revs,
  output logic [DEG_W-1:0] deg,
  output logic [FW-1:0]    frame_idx,
  output logic             rev_done,
  output logic             frame_adv,
  output pov_state_t       state
);

  localparam logic [DEG_W-1:0] DEG_TOP    = DEG_W'(DEG_MAX);
  localparam logic [FW-1:0]    LAST_FRAME = FW'(NUM_FRAMES - 1);

  logic          tick;
  logic          wrap;
  logic [7:0]    rev_cnt;
  logic [7:0]    rev_target;
  logic          step_pend;
  logic          adv_play;
  logic          adv_pause;
  logic          adv;
  logic [FW-1:0] frame_nxt;

  fan_tick_detect u_tick (
    .clk    (clk),
    .rst    (rst),
    .fanclk (fanclk),
    .tick   (tick)
  );

  assign wrap       = tick && (state != IDLE) && (deg == DEG_W'(1));
  assign rev_target = (hold_revs == 8'd0) ? 8'd0 : hold_revs - 8'd1;
  // >= rather than == so that lowering hold_revs mid-frame cannot strand
  // rev_cnt above the target; for a steady hold_revs the two are identical.
  assign adv_play   = wrap && (state == PLAY) && (rev_cnt >= rev_target);
  assign adv_pause  = wrap && (state == PAUSE) && step_pend;
  assign adv        = adv_play | adv_pause;

`ifdef PINGPONG_EN
  logic dir_up;
  logic dir_nxt;

  // dir turns around on arriving at an end frame, so each end is shown once
  always_comb begin
    frame_nxt = frame_idx;
    dir_nxt   = dir_up;
    if (NUM_FRAMES > 1) begin
      frame_nxt = dir_up ? frame_idx + FW'(1) : frame_idx - FW'(1);
      if (frame_nxt == LAST_FRAME) dir_nxt = 1'b0;
      else if (frame_nxt == '0)    dir_nxt = 1'b1;
    end
  end
`else
  always_comb begin
    frame_nxt = (frame_idx == LAST_FRAME) ? '0 : frame_idx + FW'(1);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      // reset and IDLE entry restore the same values
      state     <= IDLE;
      deg       <= DEG_TOP;
      frame_idx <= '0;
      rev_done  <= 1'b0;
      frame_adv <= 1'b0;
      rev_cnt   <= 8'd0;
      step_pend <= 1'b0;
`ifdef PINGPONG_EN
      dir_up    <= 1'b1;
`endif
    end else begin
      state     <= run ? PLAY : PAUSE;
      rev_done  <= wrap;
      frame_adv <= adv;

      if (tick && (state != IDLE))
        deg <= (deg == DEG_W'(1)) ? DEG_TOP : deg - DEG_W'(1);

      if (adv) begin
        frame_idx <= frame_nxt;
`ifdef PINGPONG_EN
        dir_up    <= dir_nxt;
`endif
      end

      // rules follow the state current at the wrap, so a PLAY->PAUSE
      // switch landing on a wrap still gets the PLAY treatment
      case (state)
        PLAY: begin
          step_pend <= 1'b0;
          if (wrap) rev_cnt <= adv_play ? 8'd0 : rev_cnt + 8'd1;
        end
        PAUSE: begin
          // a step coinciding with a wrap is kept for the following wrap
          if (wrap)      step_pend <= step;
          else if (step) step_pend <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pov_frame_scheduler.sv
module tb_pov_frame_scheduler;
  import pov_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fanclk = 1'b0;
  logic       en = 1'b0;
  logic       run = 1'b0;
  logic       step = 1'b0;
  logic [7:0] hold_revs = 8'd1;
  logic [8:0] deg;
  logic [2:0] frame_idx;
  logic       rev_done;
  logic       frame_adv;
  pov_state_t state;

  pov_frame_scheduler #(.DEG_MAX(360), .NUM_FRAMES(6), .FW(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .fanclk    (fanclk),
    .en        (en),
    .run       (run),
    .step      (step),
    .hold_revs (hold_revs),
    .deg       (deg),
    .frame_idx (frame_idx),
    .rev_done  (rev_done),
    .frame_adv (frame_adv),
    .state     (state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int rev_seen = 0;
  int adv_seen = 0;
  int adv_orphan = 0;

  typedef struct {
    logic [7:0] hold;
    int         revs;
    int         exp_frame;
    int         exp_advs;
  } row_t;

  row_t rows[10];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; run = 1'b0; step = 1'b0; fanclk = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic start_play(input logic [7:0] hold);
    hold_revs = hold;
    en = 1'b1;
    run = 1'b1;
    @(negedge clk);
  endtask

  // one fanclk pulse; outputs are sampled after the deg update has landed
  task automatic tick_ex(input logic step_v, input logic run_v);
    @(negedge clk);
    fanclk = 1'b1;
    step = step_v;
    run = run_v;
    @(negedge clk);
    fanclk = 1'b0;
    step = 1'b0;
    if (rev_done) rev_seen++;
    if (frame_adv) adv_seen++;
    if (frame_adv && !rev_done) adv_orphan++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick_ex(1'b0, run);
  endtask

  task automatic step_pulse();
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
`ifdef PINGPONG_EN
    rows[0] = '{8'd1, 1, 1, 1};
    rows[1] = '{8'd1, 1, 2, 1};
    rows[2] = '{8'd1, 1, 3, 1};
    rows[3] = '{8'd1, 1, 4, 1};
    rows[4] = '{8'd1, 1, 5, 1};
    rows[5] = '{8'd1, 1, 4, 1};
    rows[6] = '{8'd1, 1, 3, 1};
    rows[7] = '{8'd0, 1, 2, 1};
    rows[8] = '{8'd0, 1, 1, 1};
    rows[9] = '{8'd3, 3, 0, 1};
`else
    rows[0] = '{8'd1, 1, 1, 1};
    rows[1] = '{8'd1, 1, 2, 1};
    rows[2] = '{8'd1, 1, 3, 1};
    rows[3] = '{8'd1, 1, 4, 1};
    rows[4] = '{8'd1, 1, 5, 1};
    rows[5] = '{8'd1, 1, 0, 1};
    rows[6] = '{8'd1, 1, 1, 1};
    rows[7] = '{8'd0, 1, 2, 1};
    rows[8] = '{8'd0, 1, 3, 1};
    rows[9] = '{8'd3, 3, 4, 1};
`endif

    // reset values
    do_reset();
    check("rst_deg", int'(deg), 360);
    check("rst_frame", int'(frame_idx), 0);
    check("rst_rev_done", int'(rev_done), 0);
    check("rst_frame_adv", int'(frame_adv), 0);
    check("rst_state", int'(state), 0);

    // long fanclk level gives a single tick, one-cycle latency
    start_play(8'd1);
    check("play_state", int'(state), 1);
    fanclk = 1'b1;
    @(negedge clk);
    check("tick_latency_deg", int'(deg), 359);
    @(negedge clk);
    @(negedge clk);
    fanclk = 1'b0;
    check("level_high_deg", int'(deg), 359);
    @(negedge clk);
    check("level_low_deg", int'(deg), 359);

    // hold_revs=2
    do_reset();
    start_play(8'd2);
    rev_seen = 0; adv_seen = 0; adv_orphan = 0;
    ticks(359);
    check("h2_deg_at_1", int'(deg), 1);
    check("h2_no_early_wrap", rev_seen, 0);
    ticks(1);
    check("h2_wrap1_deg", int'(deg), 360);
    check("h2_wrap1_rev_done", int'(rev_done), 1);
    check("h2_wrap1_frame", int'(frame_idx), 0);
    check("h2_wrap1_adv", int'(frame_adv), 0);
    ticks(360);
    check("h2_wrap2_rev_done", int'(rev_done), 1);
    check("h2_wrap2_adv", int'(frame_adv), 1);
    check("h2_wrap2_frame", int'(frame_idx), 1);
    check("h2_adv_count", adv_seen, 1);

    // frame order table
    do_reset();
    start_play(8'd1);
    adv_orphan = 0;
    for (int r = 0; r < 10; r++) begin
      hold_revs = rows[r].hold;
      adv_seen = 0;
      ticks(rows[r].revs * 360);
      check($sformatf("order_frame_row%0d", r), int'(frame_idx), rows[r].exp_frame);
      check($sformatf("order_adv_row%0d", r), int'(frame_adv), 1);
      check($sformatf("order_advcnt_row%0d", r), adv_seen, rows[r].exp_advs);
    end
    check("order_adv_without_rev", adv_orphan, 0);

    // PLAY->PAUSE on the wrap cycle, then stepping in PAUSE
    do_reset();
    start_play(8'd1);
    ticks(359);
    tick_ex(1'b0, 1'b0);
    check("switch_wrap_frame", int'(frame_idx), 1);
    check("switch_wrap_adv", int'(frame_adv), 1);
    check("switch_state", int'(state), 2);
    ticks(260);
    check("pause_deg_100", int'(deg), 100);
    adv_seen = 0;
    for (int k = 0; k < 3; k++) begin
      step_pulse();
      ticks(1);
    end
    check("pause_frame_held", int'(frame_idx), 1);
    ticks(96);
    check("pause_deg_1", int'(deg), 1);
    check("pause_no_adv_before_wrap", adv_seen, 0);
    ticks(1);
    check("pause_step_frame", int'(frame_idx), 2);
    check("pause_step_adv", int'(frame_adv), 1);
    check("pause_step_advcnt", adv_seen, 1);
    ticks(360);
    check("pause_next_wrap_rev", int'(rev_done), 1);
    check("pause_next_wrap_adv", int'(frame_adv), 0);
    check("pause_next_wrap_frame", int'(frame_idx), 2);
    ticks(359);
    tick_ex(1'b1, 1'b0);
    check("step_on_wrap_adv", int'(frame_adv), 0);
    check("step_on_wrap_frame", int'(frame_idx), 2);
    ticks(360);
    check("step_held_adv", int'(frame_adv), 1);
    check("step_held_frame", int'(frame_idx), 3);

    // en dropped mid-revolution
    do_reset();
    start_play(8'd1);
    ticks(3 * 360 + 303);
    check("en_pre_deg", int'(deg), 57);
    check("en_pre_frame", int'(frame_idx), 3);
    en = 1'b0;
    @(negedge clk);
    check("en_off_deg", int'(deg), 360);
    check("en_off_frame", int'(frame_idx), 0);
    check("en_off_state", int'(state), 0);
    rev_seen = 0;
    ticks(5);
    check("idle_ticks_deg", int'(deg), 360);
    check("idle_ticks_state", int'(state), 0);

    // reset mid-revolution, coinciding with a fanclk edge
    en = 1'b1;
    run = 1'b1;
    @(negedge clk);
    ticks(10);
    check("mid_rst_pre_deg", int'(deg), 350);
    rst = 1'b1;
    fanclk = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    fanclk = 1'b0;
    check("mid_rst_deg", int'(deg), 360);
    check("mid_rst_state", int'(state), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
